// File: rtl/data_axi_bridge.sv
// Bridges the core's req/addr_ok/data_ok data port onto AXI4-style AR/R/AW/W/B channels, one transaction at a time.
// Optional DATA_AXI_POSTED_WRITE_EN: acknowledge writes once AW and W are done and collect B in the background.
module data_axi_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;
    logic        arvalid_reg, rready_reg, awvalid_reg, wvalid_reg;
    logic        aw_done_reg, w_done_reg;
    logic        aw_now, w_now, both_done, accept;

    assign aw_now    = aw_done_reg | (awvalid_reg & awready);
    assign w_now     = w_done_reg  | (wvalid_reg & wready);
    assign both_done = (state_reg == WR_AW_W) & aw_now & w_now;

`ifdef DATA_AXI_POSTED_WRITE_EN
    logic        b_pending_reg;
    logic [29:0] pend_addr_reg;
    logic        blocked;

    // Only a read of the word still awaiting B is held, to keep read-after-write ordering.
    assign blocked      = b_pending_reg & (data_wr | (data_addr[31:2] == pend_addr_reg));
    assign data_addr_ok = (state_reg == IDLE) & ~blocked;
    assign bready       = b_pending_reg;
    assign data_data_ok = ((state_reg == RD_R) & rvalid) | both_done;
`else
    logic bready_reg;

    assign data_addr_ok = (state_reg == IDLE);
    assign bready       = bready_reg;
    assign data_data_ok = ((state_reg == RD_R) & rvalid) | ((state_reg == WR_B) & bvalid);
`endif

    assign accept     = data_req & data_addr_ok;
    assign data_rdata = rdata;
    assign araddr     = addr_reg;
    assign awaddr     = addr_reg;
    assign arsize     = {1'b0, size_reg};
    assign awsize     = {1'b0, size_reg};
    assign wdata      = wdata_reg;
    assign wstrb      = wstrb_reg;
    assign arvalid    = arvalid_reg;
    assign rready     = rready_reg;
    assign awvalid    = awvalid_reg;
    assign wvalid     = wvalid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            size_reg    <= 2'd2;
            wstrb_reg   <= '0;
            wdata_reg   <= '0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
`ifdef DATA_AXI_POSTED_WRITE_EN
            b_pending_reg <= 1'b0;
            pend_addr_reg <= '0;
`else
            bready_reg  <= 1'b0;
`endif
        end else begin
`ifdef DATA_AXI_POSTED_WRITE_EN
            if (b_pending_reg && bvalid)
                b_pending_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg    <= data_addr;
                        // The illegal size code is treated as a full word.
                        size_reg    <= (data_size == 2'd3) ? 2'd2 : data_size;
                        wstrb_reg   <= data_wstrb;
                        wdata_reg   <= data_wdata;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        if (data_wr) begin
                            state_reg   <= WR_AW_W;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD_AR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                RD_AR: begin
                    if (arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_R;
                    end
                end
                RD_R: begin
                    if (rvalid) begin
                        rready_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                WR_AW_W: begin
                    if (awvalid_reg && awready) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (wvalid_reg && wready) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if (both_done) begin
`ifdef DATA_AXI_POSTED_WRITE_EN
                        state_reg     <= IDLE;
                        b_pending_reg <= 1'b1;
                        pend_addr_reg <= addr_reg[31:2];
`else
                        state_reg  <= WR_B;
                        bready_reg <= 1'b1;
`endif
                    end
                end
                WR_B: begin
`ifdef DATA_AXI_POSTED_WRITE_EN
                    state_reg <= IDLE;
`else
                    if (bvalid) begin
                        bready_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge; posted-write checks are compiled when DATA_AXI_POSTED_WRITE_EN is defined.
module tb_data_axi_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, araddr, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = '0;
    int          n_vec = 0, n_err = 0;

    data_axi_bridge dut (
        .clk(clk), .reset(reset), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [2:0] exp_size, input int ar_wait, input int r_wait,
                           input logic [31:0] rd, input bit keep, input logic [31:0] nxt);
        data_req = 1'b1; data_wr = 1'b0; data_size = size; data_addr = addr;
        #1 check({tag, " addr_ok_idle"}, data_addr_ok, 1);
        tick();
        if (keep) data_addr = nxt; else data_req = 1'b0;
        #1;
        check({tag, " arvalid"}, arvalid, 1);
        check({tag, " araddr"}, araddr, addr);
        check({tag, " arsize"}, arsize, exp_size);
        check({tag, " addr_ok_busy"}, data_addr_ok, 0);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            check({tag, " arvalid_hold"}, arvalid, 1);
            check({tag, " no_ok_ar"}, data_data_ok, 0);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        check({tag, " arvalid_drop"}, arvalid, 0);
        check({tag, " rready"}, rready, 1);
        for (int i = 0; i < r_wait; i++) begin
            check({tag, " no_ok_r"}, data_data_ok, 0);
            check({tag, " addr_ok_r"}, data_addr_ok, 0);
            tick();
        end
        rvalid = 1'b1; rdata = rd;
        #1;
        check({tag, " data_ok"}, data_data_ok, 1);
        check({tag, " rdata"}, data_rdata, rd);
        check({tag, " addr_ok_in_ok"}, data_addr_ok, 0);
        tick();
        rvalid = 1'b0; rdata = '0;
        #1;
        check({tag, " ok_single"}, data_data_ok, 0);
        check({tag, " rready_drop"}, rready, 0);
        if (!keep) check({tag, " addr_ok_back"}, data_addr_ok, 1);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst arvalid", arvalid, 0);
        check("rst rready", rready, 0);
        check("rst awvalid", awvalid, 0);
        check("rst wvalid", wvalid, 0);
        check("rst bready", bready, 0);
        check("rst data_ok", data_data_ok, 0);
        check("rst addr_ok", data_addr_ok, 1);

        // 1: word read with AR and R wait states
        do_read("t1", 32'h1c00_0000, 2'd2, 3'd2, 2, 2, 32'hdead_beef, 0, '0);

        // 2: byte write, W handshakes before AW
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h10;
        data_wstrb = 4'b0010; data_wdata = 32'h0000_ab00;
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        #1;
        check("t2 awvalid", awvalid, 1);
        check("t2 wvalid", wvalid, 1);
        check("t2 awaddr", awaddr, 32'h10);
        check("t2 awsize", awsize, 0);
        check("t2 wstrb", wstrb, 4'b0010);
        check("t2 wdata", wdata, 32'h0000_ab00);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        #1;
        check("t2 wvalid_drop", wvalid, 0);
        check("t2 awvalid_hold", awvalid, 1);
        check("t2 bready_early", bready, 0);
        tick();
        check("t2 awvalid_hold2", awvalid, 1);
        awready = 1'b1;
        #1;
`ifdef DATA_AXI_POSTED_WRITE_EN
        check("t2 posted_ok", data_data_ok, 1);
        tick();
        awready = 1'b0;
        #1;
        check("t2 awvalid_drop", awvalid, 0);
        check("t2 bready", bready, 1);
        check("t2 no_ok_b", data_data_ok, 0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
`else
        check("t2 no_ok_aw", data_data_ok, 0);
        tick();
        awready = 1'b0;
        #1;
        check("t2 awvalid_drop", awvalid, 0);
        check("t2 bready", bready, 1);
        check("t2 addr_ok_b", data_addr_ok, 0);
        bvalid = 1'b1;
        #1 check("t2 data_ok_b", data_data_ok, 1);
        tick();
        bvalid = 1'b0;
        #1;
        check("t2 ok_single", data_data_ok, 0);
`endif
        check("t2 bready_drop", bready, 0);
        check("t2 addr_ok_back", data_addr_ok, 1);

        // 2b: word write with AW and W in the same cycle
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h20;
        data_wstrb = 4'hf; data_wdata = 32'h1234_5678;
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        awready = 1'b1; wready = 1'b1;
        #1;
        check("t2b awsize", awsize, 2);
`ifdef DATA_AXI_POSTED_WRITE_EN
        check("t2b posted_ok", data_data_ok, 1);
`else
        check("t2b no_ok", data_data_ok, 0);
`endif
        tick();
        awready = 1'b0; wready = 1'b0;
        #1;
        check("t2b bready", bready, 1);
        check("t2b valids_low", {31'd0, awvalid | wvalid}, 0);
        bvalid = 1'b1;
`ifndef DATA_AXI_POSTED_WRITE_EN
        #1 check("t2b data_ok_b", data_data_ok, 1);
`endif
        tick();
        bvalid = 1'b0;
        #1 check("t2b bready_drop", bready, 0);

        // 3: back-to-back reads, second request held high from the start
        do_read("t3a", 32'h0, 2'd2, 3'd2, 0, 0, 32'h1111_0000, 1, 32'h4);
        do_read("t3b", 32'h4, 2'd2, 3'd2, 0, 0, 32'h2222_0004, 0, '0);

        // 4: reset while waiting for R
        data_req = 1'b1; data_addr = 32'h40; data_size = 2'd2;
        tick();
        data_req = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1 check("t4 rready_pre", rready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rvalid = 1'b1;
        #1;
        check("t4 arvalid", arvalid, 0);
        check("t4 rready", rready, 0);
        check("t4 addr_ok", data_addr_ok, 1);
        check("t4 no_ok", data_data_ok, 0);
        tick();
        rvalid = 1'b0;
        #1 check("t4 no_ok2", data_data_ok, 0);

        // 5: illegal size is issued as a word
        do_read("t5", 32'h80, 2'd3, 3'd2, 0, 1, 32'h5555_aaaa, 0, '0);

`ifdef DATA_AXI_POSTED_WRITE_EN
        // 6: posted write, then reads to the same and a different word
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h100;
        data_wstrb = 4'hf; data_wdata = 32'hcafe_f00d;
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        awready = 1'b1; wready = 1'b1;
        #1 check("t6 wr_ok", data_data_ok, 1);
        tick();
        awready = 1'b0; wready = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h300;
        #1 check("t6 wr_blocked", data_addr_ok, 0);
        data_wr = 1'b0; data_addr = 32'h100;
        #1 check("t6 rd_same_blocked", data_addr_ok, 0);
        data_addr = 32'h200;
        #1 check("t6 rd_other_ok", data_addr_ok, 1);
        tick();
        data_req = 1'b0;
        #1;
        check("t6 araddr_200", araddr, 32'h200);
        check("t6 arvalid_200", arvalid, 1);
        check("t6 bready_pending", bready, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0200_0200;
        #1 check("t6 rd200_ok", data_data_ok, 1);
        tick();
        rvalid = 1'b0;
        data_req = 1'b1; data_addr = 32'h100;
        #1 check("t6 rd_same_held", data_addr_ok, 0);
        tick();
        bvalid = 1'b1;
        #1 check("t6 held_in_b", data_addr_ok, 0);
        tick();
        bvalid = 1'b0;
        #1;
        check("t6 bready_drop", bready, 0);
        check("t6 rd_same_released", data_addr_ok, 1);
        tick();
        data_req = 1'b0;
        #1 check("t6 araddr_100", araddr, 32'h100);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hcafe_f00d;
        #1 check("t6 rd100_data", data_rdata, 32'hcafe_f00d);
        tick();
        rvalid = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_axi_bridge.md
Name: data_axi_bridge

Overview:
- Converts the core's request-style data memory port (req/addr_ok/data_ok) into a single-master AXI4-style read/write channel set.
- Sits directly downstream of the CPU core's data-memory port and upstream of the AXI interconnect.
- Handles one transaction at a time; responses return in request order.
- Burst, id, lock, cache and prot fields are fixed constants tied off in the fabric and are not ports.

Parameters:
- None. Address and data widths are fixed at 32 bits.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_req  in  1  core request valid
data_wr  in  1  1 = write, 0 = read
data_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
data_wstrb  in  4  write byte strobes
data_addr  in  32  byte address
data_wdata  in  32  write data
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  response pulse
data_rdata  out  32  read data, valid with data_ok on reads
araddr  out  32  AR address
arsize  out  3  AR size
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  R data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  AW address
awsize  out  3  AW size
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  W data
wstrb  out  4  W strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B.
- Reset: state IDLE; arvalid, rready, awvalid, wvalid, bready and data_data_ok all 0; aw_done and w_done cleared.
- Reset mid-operation aborts the transaction; outputs drop the next cycle and no data_ok is produced.
- data_addr_ok = (state == IDLE), combinational. A request is accepted when data_req & data_addr_ok.
- On accept, latch addr, size, wstrb and wdata. Size 3 is coerced to word.
- arsize/awsize = {1'b0, latched size}.
- Read path:
  - IDLE -> RD_AR; arvalid = 1 until arready.
  - RD_AR -> RD_R on arready; rready = 1 in RD_R only.
  - On rvalid in RD_R: data_data_ok = 1 that cycle, data_rdata = rdata (pass-through), return to IDLE.
- Write path:
  - IDLE -> WR_AW_W; awvalid and wvalid both asserted.
  - Each valid drops independently after its own handshake, tracked by aw_done and w_done.
  - Move to WR_B once both are done; AW and W completing in the same cycle moves immediately.
  - bready = 1 in WR_B; on bvalid, data_data_ok = 1 that cycle, return to IDLE.
- Latency: minimum 3 cycles from accept to data_ok with a zero-wait slave (accept, AR/AW, R/B). No new accept occurs in a data_ok cycle; the next accept is possible the following cycle.
- data_rdata is don't-care when data_data_ok = 0. wstrb is passed unchanged; the core is responsible for alignment.

Optional Feature:
- Macro: DATA_AXI_POSTED_WRITE_EN.
- When defined:
  - data_data_ok for a write fires in the cycle both AW and W are done; the FSM returns to IDLE and sets b_pending.
  - bready = 1 while b_pending; b_pending clears on bvalid.
  - While b_pending: write requests get addr_ok = 0; a read gets addr_ok = 0 only if data_addr[31:2] equals the pending write address [31:2]. Other reads proceed.
- When undefined: baseline behaviour, data_ok only on B.

Test Plan:
1. Read word 0x1c000000; arready after 2 cycles, rvalid with 0xdeadbeef 3 cycles later -> araddr = 0x1c000000, arsize = 2, single data_ok pulse with data_rdata = 0xdeadbeef; addr_ok = 0 from accept until data_ok.
2. Byte write addr 0x10, wstrb 4'b0010, wdata 0x0000ab00; wready 2 cycles before awready -> wvalid drops after its handshake, awvalid holds; bready only after both; data_ok on bvalid.
3. Two back-to-back reads 0x0 then 0x4 -> second req sees addr_ok = 0 until the cycle after the first data_ok; araddr order 0x0, 0x4.
4. Reset asserted while in RD_R -> next cycle arvalid = rready = 0, addr_ok = 1, no data_ok.
5. data_size = 3 read -> arsize = 3'b010.
6. With POSTED_WRITE_EN: write 0x100, bvalid delayed 5 cycles, then read 0x100 and read 0x200 -> write data_ok precedes bvalid; read 0x100 is held until the cycle after B; read 0x200 issued to AR before bvalid.
